// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: state encoding, defaults, NOP encoding.
package hazard_ctrl_pkg;

  localparam logic [1:0] StRun       = 2'd0;
  localparam logic [1:0] StMemWait   = 2'd1;
  localparam logic [1:0] StRedirPend = 2'd2;
  localparam logic [1:0] StHalted    = 2'd3;

  localparam int unsigned RegWDefault = 4;
  localparam logic [15:0] NopInstr    = 16'h4000;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator between the instruction in ID and a load in EX.
module hazard_detect #(
  parameter int unsigned REG_W = 4
) (
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rd_i,
  output logic             load_use_o
);

  logic rs_hit, rt_hit;

  assign rs_hit = id_use_rs_i && (ex_rd_i == id_rs_i);
  assign rt_hit = id_use_rt_i && (ex_rd_i == id_rt_i);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use_o = ex_memread_i && (ex_rd_i != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stall/flush control, deferred branch redirects, D-miss timeout and halt.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush cycle counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W       = RegWDefault,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_branch_taken,
  input  logic             imiss_busy,
  input  logic             dmiss_busy,
  input  logic             wb_halt,
  output logic             pc_wen,
  output logic             pc_redirect,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_flush,
  output logic             halted,
  output logic             mem_timeout_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0]      perf_stall_cnt,
  output logic [15:0]      perf_flush_cnt
`endif
);

  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

  logic [1:0] state_q, state_d;
  logic       redir_q, redir_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;
  logic       load_use;

  logic pc_wen_raw, pc_redirect_raw, ifid_stall_raw, ifid_flush_raw;
  logic idex_stall_raw, idex_flush_raw, exmem_stall_raw, memwb_flush_raw, halted_raw;

  hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard_detect (
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_use_rs_i  (id_use_rs),
    .id_use_rt_i  (id_use_rt),
    .ex_memread_i (ex_memread),
    .ex_rd_i      (ex_rd),
    .load_use_o   (load_use)
  );

  always_comb begin
    state_d         = state_q;
    redir_d         = redir_q;
    wait_cnt_d      = '0;
    err_d           = err_q;
    pc_wen_raw      = 1'b0;
    pc_redirect_raw = 1'b0;
    ifid_stall_raw  = 1'b0;
    ifid_flush_raw  = 1'b0;
    idex_stall_raw  = 1'b0;
    idex_flush_raw  = 1'b0;
    exmem_stall_raw = 1'b0;
    memwb_flush_raw = 1'b0;
    halted_raw      = 1'b0;

    if (state_q == StHalted) begin
      halted_raw      = 1'b1;
      ifid_stall_raw  = 1'b1;
      idex_stall_raw  = 1'b1;
      exmem_stall_raw = 1'b1;
    end else if (dmiss_busy) begin
      ifid_stall_raw  = 1'b1;
      idex_stall_raw  = 1'b1;
      exmem_stall_raw = 1'b1;
      memwb_flush_raw = 1'b1;
      state_d         = StMemWait;
      wait_cnt_d      = (wait_cnt_q == TimeoutCnt) ? wait_cnt_q : wait_cnt_q + 8'd1;
      if (wait_cnt_d == TimeoutCnt) begin
        err_d = 1'b1;
      end
    end else if (load_use) begin
      // Branch in ID is held by the stall and re-evaluated next cycle.
      ifid_stall_raw = 1'b1;
      idex_flush_raw = 1'b1;
      state_d        = redir_q ? StRedirPend : StRun;
    end else if (redir_q || id_branch_taken) begin
      ifid_flush_raw = 1'b1;
      if (imiss_busy) begin
        redir_d = 1'b1;
        state_d = StRedirPend;
      end else begin
        pc_wen_raw      = 1'b1;
        pc_redirect_raw = 1'b1;
        redir_d         = 1'b0;
        state_d         = StRun;
      end
    end else if (imiss_busy) begin
      ifid_flush_raw = 1'b1;
      state_d        = StRun;
    end else begin
      pc_wen_raw = 1'b1;
      state_d    = StRun;
    end

    if (wb_halt) begin
      state_d = StHalted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      redir_q    <= 1'b0;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      redir_q    <= redir_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // All outputs are held low while reset is asserted.
  assign pc_wen          = rst_n & pc_wen_raw;
  assign pc_redirect     = rst_n & pc_redirect_raw;
  assign ifid_stall      = rst_n & ifid_stall_raw;
  assign ifid_flush      = rst_n & ifid_flush_raw;
  assign idex_stall      = rst_n & idex_stall_raw;
  assign idex_flush      = rst_n & idex_flush_raw;
  assign exmem_stall     = rst_n & exmem_stall_raw;
  assign memwb_flush     = rst_n & memwb_flush_raw;
  assign halted          = rst_n & halted_raw;
  assign mem_timeout_err = rst_n & err_q;

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_wen_raw && (state_q != StHalted)) begin
        stall_cnt_q <= sat_inc16(stall_cnt_q);
      end
      if (ifid_flush_raw || idex_flush_raw) begin
        flush_cnt_q <= sat_inc16(flush_cnt_q);
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
